// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 4-word window, STATUS bit positions, serialiser state
// encodings and a small saturating helper for the STATUS count field.
package uart_tx_mmio_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // STATUS only has a 4-bit count field; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input int unsigned c);
        return (c > 32'd15) ? 4'hF : 4'(c);
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if
// CPU load/store strobes and word address as seen by the UART window.
// The shared data bus stays a separate inout on the peripheral because it
// is a resolved net shared with RAM.
//   mem_re   read strobe
//   mem_we   write strobe
//   memaddr  30-bit word address
interface uart_tx_mmio_if;
    logic        mem_re;
    logic        mem_we;
    logic [29:0] memaddr;

    modport master (output mem_re, output mem_we, output memaddr);
    modport slave  (input  mem_re, input  mem_we, input  memaddr);
endinterface

// File: rtl/uart_tx_mmio_fifo_sync.sv
// fifo_sync
// Synchronous show-ahead FIFO. dout always presents the head entry.
// Pushes while full and pops while empty are ignored; full/empty are
// judged on the count before the edge.
//   clk, rst     clock, synchronous active-high reset
//   push, din    write request and data
//   pop, dout    read request and head data
//   count        occupancy, log2(DEPTH)+1 bits
//   full, empty  occupancy flags
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped UART transmitter. Stores to DATA queue bytes in a FIFO that
// a baud-rate FSM serialises onto txd (8N1, LSB first, DIVISOR+1 clocks per
// bit). Loads return registers combinationally onto the shared bus.
//   clk, rst  clock, synchronous active-high reset
//   bus       strobes and word address (slave modport)
//   memdata   shared 32-bit data bus, driven only on a read hit
//   txd       serial output, idle high
//   irq       FIFO empty and serialiser idle (registered)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line idle high, waiting for a byte in the FIFO
// ST_START | start bit (low)
// ST_DATA  | 8 data bits, bit_idx selects the current one
// ST_STOP  | stop bit (high); may chain straight into START
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [29:0] BASE        = 30'h3FFFFFF0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    inout  wire  [31:0]   memdata,
    output logic          txd,
    output logic          irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit;
    logic [1:0]      offset;
    logic            wr_en;
    logic            data_wr;
    logic            stat_wr;
    logic            div_wr;
    logic [15:0]     divisor;
    logic            overflow;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            push_acc;
    logic            empty_nxt;
    tx_state_e       state;
    tx_state_e       state_nxt;
    logic [7:0]      shreg;
    logic [7:0]      shreg_nxt;
    logic [15:0]     bit_cnt;
    logic [15:0]     bit_cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nxt;
    logic            txd_nxt;
    logic            irq_nxt;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign hit     = (bus.memaddr[29:2] == BASE[29:2]);
    assign offset  = bus.memaddr[1:0];
    assign wr_en   = hit && bus.mem_we && !bus.mem_re;
    assign data_wr = wr_en && (offset == UART_REG_DATA);
    assign stat_wr = wr_en && (offset == UART_REG_STATUS);
    assign div_wr  = wr_en && (offset == UART_REG_DIV);

    assign unused_bits = ^memdata[31:16];

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (fifo_pop),
        .din   (memdata[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (div_wr) divisor <= memdata[15:0];
            if (data_wr && fifo_full)
                overflow <= 1'b1;
            else if (stat_wr && memdata[STAT_OVF])
                overflow <= 1'b0;
        end
    end

    // irq is registered, so it needs the FIFO occupancy after this edge.
    assign push_acc  = data_wr && !fifo_full;
    assign empty_nxt = !push_acc &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop));
    assign irq_nxt   = empty_nxt && (state_nxt == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
            irq     <= 1'b1;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            txd     <= txd_nxt;
            irq     <= irq_nxt;
        end
    end

    // bit_cnt reloads from DIVISOR at every bit boundary, so a DIVISOR write
    // mid-bit only changes the following bits.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        txd_nxt     = txd;
        fifo_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shreg_nxt   = fifo_dout;
                    txd_nxt     = 1'b0;
                    bit_cnt_nxt = divisor;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (bit_cnt == '0) begin
                    state_nxt   = ST_DATA;
                    txd_nxt     = shreg[0];
                    bit_idx_nxt = '0;
                    bit_cnt_nxt = divisor;
                end else begin
                    bit_cnt_nxt = bit_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_nxt = divisor;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        txd_nxt     = shreg[1];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        shreg_nxt   = fifo_dout;
                        txd_nxt     = 1'b0;
                        bit_cnt_nxt = divisor;
                        state_nxt   = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt - 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (offset)
            UART_REG_STATUS: begin
                rdata[STAT_BUSY]  = (state != ST_IDLE);
                rdata[STAT_FULL]  = fifo_full;
                rdata[STAT_EMPTY] = fifo_empty;
                rdata[STAT_OVF]   = overflow;
                rdata[7:4]        = sat_count4(32'(fifo_count));
            end
            UART_REG_DIV: rdata[15:0] = divisor;
            default: ;
        endcase
    end

    assign memdata = (hit && bus.mem_re) ? rdata : 'z;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
// Directed bench for uart_tx_mmio. Bytes written to DATA are queued as
// expected frames; a line monitor decodes txd and checks each frame
// against the queue head. The bus carries a pull-up so an undriven
// memdata reads as all ones.
module tb_uart_tx_mmio;
    localparam logic [29:0] BASE     = 30'h3FFFFFF0;
    localparam logic [31:0] UNDRIVEN = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] memdata;
    logic        txd;
    logic        irq;
    logic        tb_oe;
    logic [31:0] tb_wdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    int         tb_div         = 433;
    int         frames_started = 0;
    int         frames_done    = 0;
    int         mon_last_gap   = -1;
    int         mon_idle       = 0;
    int         mon_n          = 0;
    int         mon_len        = 1;
    int         mon_slot;
    bit         mon_active     = 1'b0;
    bit         mon_prev       = 1'b1;
    bit         mon_glitch     = 1'b0;
    logic       mon_lvl;
    logic [7:0] mon_exp;
    logic [7:0] mon_rx;

    uart_tx_mmio_if bus ();

    assign memdata = tb_oe ? tb_wdata : 'z;
    pullup (memdata);

    uart_tx_mmio #(
        .BASE        (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .memdata (memdata),
        .txd     (txd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] addr_of(input int off);
        return BASE + 30'(off);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.memaddr = a;
        bus.mem_we  = 1'b1;
        bus.mem_re  = 1'b0;
        tb_wdata    = d;
        tb_oe       = 1'b1;
        @(negedge clk);
        bus.mem_we  = 1'b0;
        tb_oe       = 1'b0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.memaddr = a;
        bus.mem_re  = 1'b1;
        #1 d = memdata;
        bus.mem_re  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [29:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    // Line monitor: one sample per clock; a frame is 10 bit slots of
    // tb_div+1 samples each, and every sample must hold the expected level.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
            mon_idle   = 0;
        end else if (!mon_active) begin
            if (txd === 1'b0 && mon_prev) begin
                frames_started++;
                mon_last_gap = mon_idle;
                mon_idle     = 0;
                mon_active   = 1'b1;
                mon_n        = 1;
                mon_glitch   = 1'b0;
                mon_rx       = '0;
                mon_len      = tb_div + 1;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_frame observed=start_bit expected=idle_line");
                end
                if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
                else mon_exp = 8'h00;
            end else begin
                mon_idle++;
            end
            mon_prev = txd;
        end else begin
            mon_slot = mon_n / mon_len;
            if (mon_slot == 0) mon_lvl = 1'b0;
            else if (mon_slot <= 8) mon_lvl = mon_exp[mon_slot-1];
            else mon_lvl = 1'b1;
            if (txd !== mon_lvl) mon_glitch = 1'b1;
            if (mon_slot >= 1 && mon_slot <= 8 && (mon_n % mon_len) == mon_len / 2)
                mon_rx[mon_slot-1] = txd;
            mon_n++;
            if (mon_n == 10 * mon_len) begin
                frames_done++;
                checks++;
                assert ({mon_glitch, mon_rx} === {1'b0, mon_exp}) else begin
                    failures++;
                    $error("FAIL frame observed=%h glitch=%0d expected=%h", mon_rx, mon_glitch, mon_exp);
                end
                mon_active = 1'b0;
                mon_prev   = txd;
                mon_idle   = 0;
            end
        end
    end

    initial begin
        int busy_cnt;
        logic [31:0] rd;

        rst         = 1'b1;
        bus.mem_re  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.memaddr = '0;
        tb_oe       = 1'b0;
        tb_wdata    = '0;

        // Reset defaults
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd1);
        check("rst_bus_idle", memdata, UNDRIVEN);
        read_check("rst_status", addr_of(1), 32'h4);
        read_check("rst_div", addr_of(2), 32'd433);

        // Single frame, DIVISOR=3, upper DATA bits ignored
        bus_write(addr_of(2), 32'd3);
        tb_div = 3;
        read_check("div_readback", addr_of(2), 32'd3);
        exp_q.push_back(8'hA5);
        bus_write(addr_of(0), 32'hFFFF_FFA5);
        check("push_edge_txd", 32'(txd), 32'd1);
        check("push_edge_irq", 32'(irq), 32'd0);
        @(negedge clk);
        check("start_edge_txd", 32'(txd), 32'd0);
        repeat (39) @(negedge clk);
        check("irq_in_stop", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_after_frame", 32'(irq), 32'd1);
        wait_frames(1, 100);

        // Back-to-back frames, DIVISOR=1
        bus_write(addr_of(2), 32'd1);
        tb_div = 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus_write(addr_of(0), 32'h00);
        bus_write(addr_of(0), 32'hFF);
        busy_cnt = 0;
        repeat (30) begin
            bus_read(addr_of(1), rd);
            if (rd[0]) busy_cnt++;
        end
        check("b2b_busy", 32'(busy_cnt), 32'd30);
        wait_frames(3, 200);
        check("b2b_gap", 32'(mon_last_gap), 32'd0);
        @(negedge clk);
        check("b2b_irq_end", 32'(irq), 32'd1);

        // Overflow: one byte in flight, eight queued, tenth dropped
        bus_write(addr_of(2), 32'd100);
        tb_div = 100;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h30 + 8'(i));
            bus_write(addr_of(0), 32'h30 + 32'(i));
        end
        read_check("ovf_status", addr_of(1), 32'h8B);
        bus_write(addr_of(1), 32'hFFFF_FFF7);
        read_check("ovf_hold", addr_of(1), 32'h8B);
        bus_write(addr_of(1), 32'h0000_0008);
        read_check("ovf_clear", addr_of(1), 32'h83);
        wait_frames(12, 12000);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Bus isolation
        @(negedge clk);
        check("idle_irq", 32'(irq), 32'd1);
        read_check("iso_base4", addr_of(4), UNDRIVEN);
        read_check("iso_base5", addr_of(5), UNDRIVEN);
        read_check("iso_below", addr_of(-1), UNDRIVEN);
        read_check("rsvd_read", addr_of(3), 32'h0);
        read_check("data_read", addr_of(0), 32'h0);
        bus_write(addr_of(3), 32'hFFFF_FFFF);
        bus_write(addr_of(6), 32'h0000_0007);
        bus_write(addr_of(4), 32'h0000_0055);
        read_check("iso_status", addr_of(1), 32'h4);
        read_check("iso_div", addr_of(2), 32'd100);
        repeat (20) @(negedge clk);
        check("iso_no_frame", 32'(frames_started), 32'd12);

        // Reset during DATA bit 3 of a frame with a second byte queued
        bus_write(addr_of(2), 32'd3);
        tb_div = 3;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C);
        bus_write(addr_of(0), 32'h5A);
        bus_write(addr_of(0), 32'h3C);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", 32'(txd), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_irq", 32'(irq), 32'd1);
        read_check("rst_mid_status", addr_of(1), 32'h4);
        read_check("rst_mid_div", addr_of(2), 32'd433);
        repeat (60) @(negedge clk);
        check("rst_mid_started", 32'(frames_started), 32'd13);
        check("rst_mid_done", 32'(frames_done), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish_before_2ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's word-addressed data bus. It sits directly downstream of the CPU's load/store path and sees the same `mem_re`, `mem_we`, `memaddr` and `memdata` nets as RAM. Stores to its window push bytes into a small FIFO, which a baud-rate state machine serialises onto `txd`. Loads return status and configuration combinationally, because the CPU samples `memdata` on the falling edge of the same cycle.

## Interface
- `BASE`, default 30'h3FFFFFF0: word address of the register window; must be 4-word aligned.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; must be a power of 2, minimum 2.
- `DEFAULT_DIV`, default 16'd433: reset value of DIVISOR; each bit lasts DIVISOR+1 clocks.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_re`  in  1  bus read strobe.
- `mem_we`  in  1  bus write strobe.
- `memaddr`  in  30  word address.
- `memdata`  inout  32  shared data bus; driven only during a read hit, otherwise 'z.
- `txd`  out  1  serial output, idle high.
- `irq`  out  1  high while the FIFO is empty and the serialiser is idle.

## Operation
- **Decode:** `hit` = `memaddr[29:2] == BASE[29:2]`. Offset = `memaddr[1:0]`.
- **Offset 0, DATA.**
  - Write pushes `memdata[7:0]` into the FIFO; bits [31:8] are ignored.
  - Read returns 0.
- **Offset 1, STATUS (read).**
  - bit0 busy (state != IDLE); bit1 fifo_full; bit2 fifo_empty; bit3 overflow (sticky).
  - bits[7:4] fifo count, saturating at 15; all other bits 0.
- **Offset 1, STATUS (write).** Writing 1 to bit3 clears overflow; all other bits are ignored.
- **Offset 2, DIVISOR.** Read/write, bits [15:0]; upper bits read 0.
- **Offset 3.** Reserved: reads 0, writes ignored.
- **Bus write qualifier:** `hit && mem_we && !mem_re`, sampled at the rising edge.
- **Bus read drive:** `memdata` is driven with the selected register when `hit && mem_re`. The read is combinational, with no side effects.
- **Write to DATA while full:**
  - Byte is dropped and overflow is set.
  - Full is judged on the pre-edge count, so the write is dropped even if a pop happens on the same edge.
- **Serialiser FSM** (IDLE, START, DATA, STOP):
  - IDLE and FIFO non-empty: pop the head into an 8-bit shift register, `txd` <= 0, bit counter <= DIVISOR, go to START.
  - START to DATA when the bit counter reaches 0.
  - DATA sends 8 bits LSB first. Each bit holds for DIVISOR+1 clocks. A 3-bit index counts bits; after bit 7, go to STOP with `txd` <= 1.
  - STOP holds DIVISOR+1 clocks, then:
    - FIFO non-empty: pop and go to START directly (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- **DIVISOR changes:** the bit counter reloads from DIVISOR at each bit boundary. A write mid-bit takes effect from the next bit.
- **Simultaneous push and pop** on one edge (not full): both happen, and the count is unchanged.

## Timing
- **Reset values:**
  - `txd`=1, `irq`=1, `memdata`='z;
  - state IDLE, FIFO empty (pointers 0), overflow 0, DIVISOR=`DEFAULT_DIV`.
- **Reset mid-frame:** `txd` returns to 1 at the reset edge. The FIFO contents and the in-flight byte are discarded.
- **Push-to-start latency** (idle block):
  - the push lands at edge k;
  - the pop and `txd` falling happen at edge k+1.
- **Frame length:** 10×(DIVISOR+1) clocks from the `txd` fall to the end of STOP.
- **STATUS after a write:** reflects the write from the first cycle after edge k (combinational on registered state).
- **`irq`:** registered; deasserts at the same edge the FIFO becomes non-empty.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. The count width is log2(`FIFO_DEPTH`)+1.

## Structure
- Shared defines/package holds:
  - register offsets (`UART_REG_DATA`, `UART_REG_STATUS`, `UART_REG_DIV`);
  - STATUS bit positions;
  - FSM state encodings (2 bits).
- One sub-module: `fifo_sync`.
  - Parameters: WIDTH, DEPTH.
  - Ports: `push`, `pop`, `din`, `dout` (head, show-ahead), `count`, `full`, `empty`.
  - Reset is synchronous, via `rst`.
- Top level holds: bus decode, register file, read mux/tristate, baud counter, serialiser FSM.

## Test plan
- **Reset default:** assert `rst` 2 cycles, then read offset 1.
  - Expect STATUS = 32'h4 (empty).
  - Expect `txd`=1, `irq`=1.
- **Single frame:**
  - Write DIVISOR=3, then DATA=32'hA5.
  - Expect `txd` to be 0 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1.
  - Total 40 clocks; `irq`=1 after.
- **Back-to-back frames:** with DIVISOR=1, push 0x00 and 0xFF.
  - Expect no idle gap between the STOP of frame 1 and the START of frame 2.
  - Expect STATUS busy throughout.
- **Overflow:** with DIVISOR=100, push 10 bytes.
  - Expect 1 byte in flight and 8 in the FIFO.
  - Expect STATUS bits 1 and 3 set and count=8; the 10th byte is never transmitted.
  - Write STATUS=8: overflow clears.
- **Bus isolation:**
  - Read at `BASE`+4: `memdata` stays 'z.
  - A write at `BASE`+3 changes nothing.
  - A read at `BASE`+2 returns the DIVISOR value.
- **Reset mid-frame:** pulse `rst` during DATA bit 3.
  - `txd`=1 next cycle; FIFO empty; no further frames.
